// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared widths, the 8-bit float record and its saturation
// constants for the fpcvt_sched slice.
package fpcvt_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned MAG_W    = 11;
  localparam int unsigned EXP_W    = 3;
  localparam int unsigned SIG_W    = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp8_t;

  localparam logic [EXP_W-1:0] FP_SAT_EXP = 3'd7;
  localparam logic [SIG_W-1:0] FP_SAT_SIG = 4'd15;

endpackage

// File: rtl/fpcvt_core.sv
// fpcvt_core: combinational 12-bit two's-complement to 8-bit float converter.
//   sample : signed linear input
//   fp     : {sign, exp, sig}, rounded half-up, saturating at exp=7/sig=15
module fpcvt_core
  import fpcvt_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample,
  output fp8_t                fp
);

  localparam int unsigned IDX_W = $clog2(MAG_W);

  logic [SAMPLE_W-1:0] neg;
  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    shifted;
  logic [EXP_W-1:0]    exp_raw;
  logic [IDX_W-1:0]    rnd_idx;
  logic                rnd;
  logic [SIG_W:0]      sum;

  always_comb begin
    neg = -sample;
    // -2048 has no 11-bit magnitude; clamp it to full scale
    if (sample == {1'b1, {MAG_W{1'b0}}}) begin
      mag = '1;
    end else if (sample[SAMPLE_W-1]) begin
      mag = neg[MAG_W-1:0];
    end else begin
      mag = sample[MAG_W-1:0];
    end

    // ascending scan: the highest set bit from mag[4] upward sets the exponent
    exp_raw = '0;
    for (int unsigned b = SIG_W; b < MAG_W; b++) begin
      if (mag[b]) exp_raw = EXP_W'(b - (SIG_W - 1));
    end

    shifted = mag >> exp_raw;
    rnd_idx = IDX_W'(exp_raw) - IDX_W'(1);
    rnd     = 1'b0;
    if (exp_raw != '0) rnd = mag[rnd_idx];

    sum     = {1'b0, shifted[SIG_W-1:0]} + {{SIG_W{1'b0}}, rnd};
    fp.sign = sample[SAMPLE_W-1];
    fp.exp  = exp_raw;
    fp.sig  = sum[SIG_W-1:0];
    if (sum[SIG_W]) begin
      if (exp_raw == FP_SAT_EXP) begin
        fp.exp = FP_SAT_EXP;
        fp.sig = FP_SAT_SIG;
      end else begin
        fp.exp = exp_raw + EXP_W'(1);
        fp.sig = {1'b1, {(SIG_W-1){1'b0}}};
      end
    end
  end

endmodule

// File: rtl/fpcvt_sched.sv
// fpcvt_sched: round-robin scheduler sharing one 2-stage float conversion
// pipeline among N_REQ requesters.
//   req_valid/req_data/req_ready : per-requester 12-bit sample handshake
//   out_valid/out_data/out_id    : converted float and source index
//   out_ready                    : downstream backpressure
module fpcvt_sched #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [12*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  output logic [ID_W-1:0]      out_id,
  input  logic                 out_ready
);
  import fpcvt_pkg::*;

  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic                s1_valid_q, s1_valid_d;
  logic [SAMPLE_W-1:0] s1_data_q, s1_data_d;
  logic [ID_W-1:0]     s1_id_q, s1_id_d;
  logic                s2_valid_q, s2_valid_d;
  fp8_t                s2_data_q, s2_data_d;
  logic [ID_W-1:0]     s2_id_q, s2_id_d;

  logic                found;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     cand;
  logic                s1_free;
  logic                s2_load;
  logic                accept;
  fp8_t                s1_fp;

  fpcvt_core u_core (
    .sample (s1_data_q),
    .fp     (s1_fp)
  );

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_free = !s1_valid_q || s2_load;
    accept  = found && s1_free && !rst;

    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;

    ptr_d = ptr_q;
    if (accept) ptr_d = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_id_d    = s1_id_q;
    if (s1_free) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_data_d = req_data[SAMPLE_W*grant +: SAMPLE_W];
        s1_id_d   = grant;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_fp;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_id    = s2_id_q;

endmodule

// File: tb/tb_fpcvt_sched.sv
// tb_fpcvt_sched: table vectors, directed handshake sequences and a random
// run against a queue-based reference of the scheduler and converter.
module tb_fpcvt_sched;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = $clog2(N_REQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [12*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [ID_W-1:0]     out_id;
  logic                out_ready;

  fpcvt_sched #(.N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic [7:0]  e;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    int unsigned id;
    int unsigned stamp;
  } item_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned edge_n   = 0;
  int unsigned ptr_m    = 0;
  item_t       q[$];
  int unsigned acc_log[$];
  int unsigned out_log[$];
  logic [N_REQ-1:0] acc_m;
  logic [11:0] specials [8] = '{12'h000, 12'h7FF, 12'h800, 12'h801,
                                12'h03F, 12'hFFF, 12'h01F, 12'h00F};

  // rounding written as integer round-half-up on mag / 2^e
  function automatic logic [7:0] ref_conv(input logic [11:0] d);
    int s, dv, mag, e, m;
    dv  = int'({20'd0, d});
    s   = int'({31'd0, d[11]});
    mag = (s != 0) ? 4096 - dv : dv;
    if (mag > 2047) mag = 2047;
    e = 0;
    while (mag >= (16 << e)) e++;
    m = (e > 0) ? ((mag + (1 << (e - 1))) >> e) : mag;
    if (m == 16) begin
      m = 8;
      e++;
    end
    if (e > 7) begin
      e = 7;
      m = 15;
    end
    return {d[11], e[2:0], m[3:0]};
  endfunction

  function automatic logic [11:0] pick_sample();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 7)];
    return 12'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // one clock: compare at the negedge against the model, then advance past posedge
  task automatic step();
    bit               found;
    bit               free;
    bit               exp_valid;
    int unsigned      g;
    logic [N_REQ-1:0] exp_ready;
    item_t            it;
    @(negedge clk);
    found = 0;
    g     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned c;
      c = (ptr_m + k) % N_REQ;
      if (!found && req_valid[c]) begin
        found = 1;
        g     = c;
      end
    end
    free      = (q.size() < 2) || (out_ready == 1'b1);
    exp_ready = '0;
    if (found && free && !rst) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    exp_valid = (q.size() > 0) && (q[0].stamp < edge_n) && !rst;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid && out_valid) begin
      check("out_data", 32'(out_data), 32'(ref_conv(q[0].data)));
      check("out_id", 32'(out_id), q[0].id);
    end
    acc_m = req_valid & req_ready;
    for (int unsigned k = 0; k < N_REQ; k++) if (acc_m[k]) acc_log.push_back(k);
    if (out_valid && out_ready) out_log.push_back(32'(out_id));
    if (exp_valid && out_ready) void'(q.pop_front());
    if (exp_ready != '0) begin
      it.data  = req_data[12*g +: 12];
      it.id    = g;
      it.stamp = edge_n + 1;
      q.push_back(it);
      ptr_m = (g + 1) % N_REQ;
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out_id", 32'(out_id), 32'd0);
    q.delete();
    ptr_m = 0;
    step();
    rst = 1'b0;
    acc_log.delete();
    out_log.delete();
  endtask

  task automatic drive_rand(input logic [N_REQ-1:0] mask, input int unsigned pct_valid);
    for (int i = 0; i < N_REQ; i++) begin
      if (acc_m[i] || !req_valid[i]) begin
        req_valid[i]       = mask[i] && ($urandom_range(0, 99) < pct_valid);
        req_data[12*i +: 12] = pick_sample();
      end
    end
  endtask

  // single sample on requester 0 with exact-latency checks
  task automatic send0(input logic [11:0] d, input logic [7:0] e);
    bit got;
    req_valid          = '0;
    req_valid[0]       = 1'b1;
    req_data[11:0]     = d;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (acc_m[0]) got = 1;
    end
    req_valid[0] = 1'b0;
    check("vec accepted", 32'(got), 32'd1);
    check("vec s1 no output", 32'(out_valid), 32'd0);
    step();
    check("vec out_valid", 32'(out_valid), 32'd1);
    check("vec out_data", 32'(out_data), 32'(e));
    check("vec out_id", 32'(out_id), 32'd0);
    step();
  endtask

  vec_t tbl [13];

  initial begin
    int unsigned a0;
    int unsigned bad;
    logic [7:0]      held;
    logic [ID_W-1:0] hid;

    tbl = '{'{12'h000, 8'h00}, '{12'd422, 8'h5D}, '{12'hE5A, 8'hDD},
            '{12'd63,  8'h38}, '{12'h7FF, 8'h7F}, '{12'h800, 8'hFF},
            '{12'd15,  8'h0F}, '{12'd16,  8'h18}, '{12'hFFF, 8'h81},
            '{12'd31,  8'h28}, '{12'd1000, 8'h78}, '{12'd24, 8'h1C},
            '{12'h801, 8'hFF}};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
    acc_m     = '0;
    do_reset();

    // conversion table through requester 0
    for (int i = 0; i < 13; i++) send0(tbl[i].d, tbl[i].e);

    // all requesters streaming: ids cycle with no gaps
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N_REQ; i++) req_data[12*i +: 12] = pick_sample();
    for (int i = 0; i < 20; i++) begin
      step();
      drive_rand('1, 100);
    end
    check("rr output count", out_log.size(), 32'd18);
    for (int i = 0; i < 12; i++) check("rr id order", out_log[i], 32'(i % N_REQ));

    // only requesters 1 and 3
    do_reset();
    req_valid = 4'b1010;
    for (int i = 0; i < 12; i++) begin
      step();
      drive_rand(4'b1010, 100);
    end
    for (int i = 0; i < 6; i++) check("odd grant order", acc_log[i], (i % 2 == 0) ? 32'd1 : 32'd3);

    // backpressure: 5 stalled cycles mid-stream
    do_reset();
    req_valid = '1;
    for (int i = 0; i < 6; i++) begin
      step();
      drive_rand('1, 100);
    end
    out_ready = 1'b0;
    held = out_data;
    hid  = out_id;
    a0   = acc_log.size();
    for (int i = 0; i < 5; i++) begin
      step();
      drive_rand('1, 100);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_data", 32'(out_data), 32'(held));
      check("stall out_id", 32'(out_id), 32'(hid));
      check("stall req_ready", 32'(req_ready), 32'd0);
    end
    check("stall no accepts", acc_log.size(), a0);
    check("in flight", acc_log.size() - out_log.size(), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      drive_rand('1, 100);
    end
    bad = 0;
    for (int i = 0; i < out_log.size(); i++) if (out_log[i] != acc_log[i]) bad++;
    check("drain order", bad, 32'd0);
    check("drain backlog", acc_log.size() - out_log.size(), 32'd2);

    // reset with both stages full
    out_ready = 1'b0;
    step();
    step();
    check("full out_valid", 32'(out_valid), 32'd1);
    check("full req_ready", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    req_valid = '1;
    do_reset();
    step();
    check("post-reset grant", 32'(acc_m), 32'd1);

    // random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      drive_rand('1, 55);
      out_ready = ($urandom_range(0, 99) < 70);
      if (i == 700) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
